mem_copy_engine: RTL and testbench
==================================

Name: mem_copy_engine

Overview:
- Bus initiator that drives the word-addressed memory port: one-cycle write strobe, combinational read data, word index taken from address[31:2].
- Copies a block of LEN 32-bit words from a source byte address to a destination byte address in the shared memory.
- Sits beside the mips core as the second initiator on the memory port. The top level owns the mux between the core and this engine (engine selected while busy=1).

Parameters:
- LEN_W, 16, width of the word-count input; the maximum transfer is 2^LEN_W-1 words.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  request pulse; sampled only in IDLE.
- src_addr  input  32  source byte address; must be word aligned.
- dst_addr  input  32  destination byte address; must be word aligned.
- len  input  LEN_W  number of words to copy.
- busy  output  1  high from the cycle after an accepted start until DONE is left.
- done  output  1  one-cycle pulse when the transfer completes.
- err  output  1  one-cycle pulse when a start is rejected for misalignment.
- mem_we  output  1  write enable to the memory (the memory's we).
- mem_a  output  32  byte address to the memory.
- mem_wd  output  32  write data to the memory.
- mem_rd  input  32  read data from the memory; combinational from mem_a.

Behaviour:
- States: IDLE, RD, WR, DONE. State and all outputs are registered or decoded from registered state.
- Reset (reset=0) forces the following immediately, regardless of clk:
  - state=IDLE;
  - busy, done, err, mem_we = 0;
  - mem_a = 0, mem_wd = 0;
  - internal src/dst pointers and remaining count = 0.
- Reset mid-transfer aborts with no further writes. Words already written stay written.
- IDLE:
  - start=1 with src_addr[1:0] and dst_addr[1:0] both 0: latch src, dst, len. If len=0, go to DONE; otherwise go to RD.
  - start=1 with either address misaligned: pulse err for one cycle, stay in IDLE, no memory access, busy stays 0.
- RD:
  - mem_a = src pointer, mem_we = 0.
  - At the clock edge: capture mem_rd into the data buffer, then go to WR.
- WR:
  - mem_a = dst pointer, mem_wd = buffer, mem_we = 1 for exactly this cycle.
  - At the edge: src += 4, dst += 4, count -= 1. If the new count is 0, go to DONE; otherwise go to RD.
- DONE:
  - done=1 for one cycle, then go to IDLE.
  - busy=1 in RD, WR and DONE only.
- Latency: start accepted at edge N; the first write is in cycle N+2; done is asserted in cycle N+2*len+1.
- Throughput: 2 cycles per word.
- start while busy: ignored, not queued.
- Pointer arithmetic is 32-bit modulo 2^32. A transfer crossing 0xFFFFFFFC wraps to 0x00000000 with no error.
- Overlap: strictly ascending, read-then-write per word.
  - Example: dst=src+4 replicates word src[0] across the whole destination. This is defined behaviour; the bench checks it.
- len = 2^LEN_W-1 must complete without count underflow.
- mem_a outside RD/WR is 0. mem_wd holds its last value.

Optional Feature:
- Macro COPY_CHECKSUM_EN.
- Defined:
  - Adds output port csum, 32 bits.
  - csum clears to 0 on an accepted start and on reset.
  - In each WR cycle, csum += buffer, modulo 2^32.
  - csum is stable and valid from the done cycle until the next accepted start.
- Undefined: port and adder are absent; behaviour is otherwise identical.

Test Plan:
- Basic copy: memory words 0..3 preloaded with 0x11111111, 0x22222222, 0x33333333, 0x44444444. Start with src=0x00, dst=0x40, len=4.
  - Words 16..19 equal the source words.
  - done is asserted exactly 9 cycles after the start edge.
  - mem_we is high in 4 non-adjacent cycles.
  - With COPY_CHECKSUM_EN: csum=0xAAAAAAAA.
- Zero length: start with len=0.
  - done is asserted in the next cycle, mem_we never goes high, busy is high for exactly 1 cycle.
- Misaligned: start with src=0x02, dst=0x40, len=3.
  - err is pulsed for 1 cycle; busy, done and mem_we stay 0; memory is unchanged.
- Overlap: words 0..2 preloaded with 0xA, 0xB, 0xC. Start with src=0x00, dst=0x04, len=2.
  - Words 1..2 become 0xA, 0xA.
- Reset mid-transfer: len=8, drive reset=0 during the 3rd WR cycle.
  - mem_we drops immediately, the state returns to IDLE, and the remaining destination words are unchanged.
  - After reset is released, a new start (len=1) completes normally.
- Busy start ignored and wrap:
  - Pulse start again while busy: no second transfer.
  - Separately, src=0xFFFFFFFC with len=2 reads word index 0x3FFFFFFF and then 0x0.

Source files
------------

// File: rtl/mem_copy_engine.sv
// mem_copy_engine: second bus initiator on the word-addressed memory port.
// Copies LEN 32-bit words from a source byte address to a destination byte
// address, one read cycle then one write cycle per word, ascending order.
// Optional build macro: COPY_CHECKSUM_EN adds a running 32-bit sum (csum) of
// every word written during the current transfer.
module mem_copy_engine #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             mem_we,
    output logic [31:0]      mem_a,
    output logic [31:0]      mem_wd,
    input  logic [31:0]      mem_rd
`ifdef COPY_CHECKSUM_EN
    ,
    output logic [31:0]      csum
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      src_q, src_d;
    logic [31:0]      dst_q, dst_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [31:0]      buf_q, buf_d;
    logic             err_q, err_d;
    logic [31:0]      csum_q, csum_d;

    logic aligned;
    assign aligned = (src_addr[1:0] == 2'b00) && (dst_addr[1:0] == 2'b00);

    // State and datapath registers; reset aborts immediately, so mem_we drops
    // without waiting for a clock edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            src_q   <= 32'd0;
            dst_q   <= 32'd0;
            cnt_q   <= '0;
            buf_q   <= 32'd0;
            err_q   <= 1'b0;
            csum_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            err_q   <= err_d;
            csum_q  <= csum_d;
        end
    end

    // Next-state and datapath update; count is checked before decrementing so
    // the maximum length never underflows.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        err_d   = 1'b0;
        csum_d  = csum_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (aligned) begin
                        src_d   = src_addr;
                        dst_d   = dst_addr;
                        cnt_d   = len;
                        csum_d  = 32'd0;
                        state_d = (len == '0) ? S_DONE : S_RD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_RD: begin
                buf_d   = mem_rd;
                state_d = S_WR;
            end
            S_WR: begin
                src_d   = src_q + 32'd4;
                dst_d   = dst_q + 32'd4;
                cnt_d   = cnt_q - LEN_W'(1);
                csum_d  = csum_q + buf_q;
                state_d = (cnt_q == LEN_W'(1)) ? S_DONE : S_RD;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from registered state; the address bus is parked at 0
    // when no memory access is in progress.
    always_comb begin
        busy   = (state_q != S_IDLE);
        done   = (state_q == S_DONE);
        mem_we = (state_q == S_WR);
        mem_wd = buf_q;
        err    = err_q;
        mem_a  = 32'd0;
        if (state_q == S_RD) begin
            mem_a = src_q;
        end else if (state_q == S_WR) begin
            mem_a = dst_q;
        end
    end

`ifdef COPY_CHECKSUM_EN
    assign csum = csum_q;
`else
    // Without the checksum output the running sum has no observer.
    logic csum_unused;
    assign csum_unused = ^csum_q;
`endif

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine: a behavioural memory, a reference copy
// model that queues expected writes, and a per-cycle monitor that pops and
// compares each write the engine issues.
module tb_mem_copy_engine;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] len;
    logic        busy;
    logic        done;
    logic        err;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;
`ifdef COPY_CHECKSUM_EN
    logic [31:0] csum;
`endif

    logic [31:0] mem [0:255];
    assign mem_rd = mem[mem_a[9:2]];

    mem_copy_engine #(.LEN_W(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .mem_we   (mem_we),
        .mem_a    (mem_a),
        .mem_wd   (mem_wd),
        .mem_rd   (mem_rd)
`ifdef COPY_CHECKSUM_EN
        ,
        .csum     (csum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // scoreboard and per-transfer statistics
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic [31:0] rd_q[$];
    logic [31:0] exp_csum;
    int cyc, we_cnt, busy_cnt, done_cnt, err_cnt, done_cyc, adj;
    logic last_we;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic clear_stats();
        cyc = 0; we_cnt = 0; busy_cnt = 0; done_cnt = 0; err_cnt = 0;
        done_cyc = -1; adj = 0; last_we = 1'b0;
        rd_q.delete();
    endtask

    // One cycle: sample at the falling edge, check any write against the
    // scoreboard and apply it to the memory.
    task automatic step();
        logic [31:0] ea, ed;
        @(negedge clk);
        cyc++;
        if (busy === 1'b1) busy_cnt++;
        if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
        if (err === 1'b1) err_cnt++;
        if (busy === 1'b1 && done === 1'b0 && mem_we === 1'b0) rd_q.push_back(mem_a);
        if (mem_we === 1'b1) begin
            we_cnt++;
            if (last_we) adj++;
            if (exp_addr_q.size() == 0) begin
                chk("unexpected_write_addr", mem_a, 32'hxxxxxxxx);
            end else begin
                ea = exp_addr_q.pop_front();
                ed = exp_data_q.pop_front();
                chk("write_addr", mem_a, ea);
                chk("write_data", mem_wd, ed);
            end
            mem[mem_a[9:2]] = mem_wd;
        end
        last_we = mem_we;
    endtask

    // Reference behaviour: ascending read-then-write per word on a copy of memory.
    task automatic push_model(input logic [31:0] s, input logic [31:0] d, input int n);
        logic [31:0] rm [0:255];
        logic [31:0] sa, da, w;
        for (int i = 0; i < 256; i++) rm[i] = mem[i];
        exp_csum = 32'd0;
        for (int i = 0; i < n; i++) begin
            sa = s + 32'(4 * i);
            da = d + 32'(4 * i);
            w = rm[sa[9:2]];
            rm[da[9:2]] = w;
            exp_addr_q.push_back(da);
            exp_data_q.push_back(w);
            exp_csum = exp_csum + w;
        end
    endtask

    task automatic kick(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
        clear_stats();
        src_addr = s; dst_addr = d; len = n; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int k = 0;
        while (done_cnt == 0 && k < bound) begin
            step();
            k++;
        end
        chk("done_seen", 32'(done_cnt != 0), 32'd1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : stim
        logic [31:0] sum_before, sum_after;
        reset = 1'b0; start = 1'b0; src_addr = 32'd0; dst_addr = 32'd0; len = 16'd0;
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        clear_stats();
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_mem_wd", mem_wd, 32'd0);
        step(); step();
        reset = 1'b1;
        step();

        // basic copy
        mem[0] = 32'h11111111; mem[1] = 32'h22222222;
        mem[2] = 32'h33333333; mem[3] = 32'h44444444;
        push_model(32'h0, 32'h40, 4);
        kick(32'h0, 32'h40, 16'd4);
        wait_done(20);
        repeat (2) step();
        chk("basic_done_cyc", 32'(done_cyc), 32'd9);
        chk("basic_we_cnt", 32'(we_cnt), 32'd4);
        chk("basic_we_adjacent", 32'(adj), 32'd0);
        chk("basic_busy_cnt", 32'(busy_cnt), 32'd9);
        chk("basic_first_rd", rd_q[0], 32'h0);
        chk("basic_w16", mem[16], 32'h11111111);
        chk("basic_w19", mem[19], 32'h44444444);
        chk("basic_sb_left", 32'(exp_addr_q.size()), 32'd0);
`ifdef COPY_CHECKSUM_EN
        chk("basic_csum", csum, 32'hAAAAAAAA);
        chk("basic_csum_model", csum, exp_csum);
`endif

        // zero length
        kick(32'h0, 32'h80, 16'd0);
        wait_done(5);
        repeat (2) step();
        chk("zero_done_cyc", 32'(done_cyc), 32'd1);
        chk("zero_we_cnt", 32'(we_cnt), 32'd0);
        chk("zero_busy_cnt", 32'(busy_cnt), 32'd1);

        // misaligned source
        sum_before = 32'd0;
        for (int i = 0; i < 256; i++) sum_before = sum_before + mem[i] + 32'(i) * mem[i];
        kick(32'h2, 32'h40, 16'd3);
        chk("mis_err_cyc1", 32'(err_cnt), 32'd1);
        repeat (5) step();
        sum_after = 32'd0;
        for (int i = 0; i < 256; i++) sum_after = sum_after + mem[i] + 32'(i) * mem[i];
        chk("mis_err_cnt", 32'(err_cnt), 32'd1);
        chk("mis_busy_cnt", 32'(busy_cnt), 32'd0);
        chk("mis_done_cnt", 32'(done_cnt), 32'd0);
        chk("mis_we_cnt", 32'(we_cnt), 32'd0);
        chk("mis_mem_sum", sum_after, sum_before);

        // overlapping ascending copy
        mem[0] = 32'hA; mem[1] = 32'hB; mem[2] = 32'hC;
        push_model(32'h0, 32'h4, 2);
        kick(32'h0, 32'h4, 16'd2);
        wait_done(12);
        repeat (2) step();
        chk("ovl_w1", mem[1], 32'hA);
        chk("ovl_w2", mem[2], 32'hA);
        chk("ovl_done_cyc", 32'(done_cyc), 32'd5);

        // reset during the third write
        for (int i = 0; i < 8; i++) begin
            mem[32 + i] = 32'h1000 + 32'(i);
            mem[48 + i] = 32'd0;
        end
        push_model(32'h80, 32'hC0, 8);
        kick(32'h80, 32'hC0, 16'd8);
        begin
            int k = 0;
            while (we_cnt < 2 && k < 20) begin step(); k++; end
        end
        chk("rstmid_two_writes", 32'(we_cnt), 32'd2);
        step();
        @(posedge clk);
        #1;
        chk("rstmid_in_wr3", 32'(mem_we), 32'd1);
        reset = 1'b0;
        #1;
        chk("rstmid_we_drop", 32'(mem_we), 32'd0);
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_mem_a", mem_a, 32'd0);
        exp_addr_q.delete();
        exp_data_q.delete();
        repeat (2) step();
        reset = 1'b1;
        step();
        chk("rstmid_w48", mem[48], 32'h1000);
        chk("rstmid_w49", mem[49], 32'h1001);
        chk("rstmid_w50", mem[50], 32'd0);
        chk("rstmid_w55", mem[55], 32'd0);
        push_model(32'h80, 32'h100, 1);
        kick(32'h80, 32'h100, 16'd1);
        wait_done(8);
        repeat (2) step();
        chk("rstmid_after_done_cyc", 32'(done_cyc), 32'd3);
        chk("rstmid_after_w64", mem[64], 32'h1000);

        // start while busy is ignored
        mem[192] = 32'h5A5A5A5A;
        push_model(32'h0, 32'h200, 2);
        kick(32'h0, 32'h200, 16'd2);
        src_addr = 32'h8; dst_addr = 32'h300; len = 16'd2; start = 1'b1;
        step();
        start = 1'b0;
        wait_done(10);
        repeat (6) step();
        chk("busy_start_done_cnt", 32'(done_cnt), 32'd1);
        chk("busy_start_we_cnt", 32'(we_cnt), 32'd2);
        chk("busy_start_w192", mem[192], 32'h5A5A5A5A);
        chk("busy_start_sb_left", 32'(exp_addr_q.size()), 32'd0);

        // address wrap at the top of the space
        mem[255] = 32'hCAFEF00D; mem[0] = 32'h0BADBEEF;
        push_model(32'hFFFFFFFC, 32'h140, 2);
        kick(32'hFFFFFFFC, 32'h140, 16'd2);
        wait_done(10);
        repeat (2) step();
        chk("wrap_rd0", rd_q[0], 32'hFFFFFFFC);
        chk("wrap_rd1", rd_q[1], 32'h00000000);
        chk("wrap_w80", mem[80], 32'hCAFEF00D);
        chk("wrap_w81", mem[81], 32'h0BADBEEF);
`ifdef COPY_CHECKSUM_EN
        chk("wrap_csum", csum, 32'hCAFEF00D + 32'h0BADBEEF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
